// File: rtl/kmeans_pkg.sv
// Shared kMeans definitions: FSM state encoding and default word width.
package kmeans_pkg;

    localparam int KM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } kmeans_state_t;

endpackage

// File: rtl/kmeans_buf_ram.sv
// DEPTH x DATA_W register file: one synchronous write port, one registered read port.
module kmeans_buf_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Plain storage with no reset so an SRAM macro can replace it one-for-one.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/kmeans_burst_buffer.sv
// Captures one contiguous input burst and replays it in order as one contiguous output burst.
module kmeans_burst_buffer
    import kmeans_pkg::*;
#(
    parameter  int DATA_W = KM_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              overflow,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    kmeans_state_t     state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       out_cnt;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata_p1;

    assign ram_we = in_valid && ((state == IDLE) || ((state == LOAD) && (count != FULL)));

    kmeans_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata_p1)
    );

    // rd_ptr runs one word ahead of the output: the RAM read of a word is
    // issued one edge before that word is registered onto out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_cnt   <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wr_ptr   <= AW'(1);
                        count    <= (AW + 1)'(1);
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (count != FULL) begin
                            wr_ptr <= wr_ptr + AW'(1);
                            count  <= count + (AW + 1)'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else begin
                        rd_ptr <= rd_ptr + AW'(1);
                        state  <= GAP;
                    end
                end
                GAP: begin
                    out_valid <= 1'b1;
                    out_data  <= ram_rdata_p1;
                    out_cnt   <= (AW + 1)'(1);
                    rd_ptr    <= rd_ptr + AW'(1);
                    state     <= DRAIN;
                    if (in_valid) overflow <= 1'b1;
                end
                DRAIN: begin
                    if (out_cnt == count) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        busy      <= 1'b0;
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        out_cnt   <= '0;
                        state     <= IDLE;
                    end else begin
                        out_data <= ram_rdata_p1;
                        out_cnt  <= out_cnt + (AW + 1)'(1);
                        rd_ptr   <= rd_ptr + AW'(1);
                        if (in_valid) overflow <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kmeans_burst_buffer.sv
// Directed bench for kmeans_burst_buffer: bursts, overflow, protocol error, reset, back-to-back.
module tb_kmeans_burst_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int AW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              overflow;
    logic [AW:0]       count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] q[$];

    kmeans_burst_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives q as one contiguous burst, returning at the negedge after in_valid falls.
    task automatic drive_burst();
        foreach (q[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = q[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Expects exp_words consecutive outputs matching q[0..], 2 cycles after in_valid fell.
    task automatic expect_replay(input string tag, input int exp_words, input bit inject);
        int cyc;
        cyc = 1;
        @(negedge clk);
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_latency"}, cyc, 2);
        for (int i = 0; i < exp_words; i++) begin
            check_eq({tag, "_valid"}, {31'b0, out_valid}, 1);
            check_eq({tag, "_data"}, {16'b0, out_data}, {16'b0, q[i]});
            in_valid = inject && (i == 1);
            in_data  = 16'hDEAD;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
        check_eq({tag, "_end_valid"}, {31'b0, out_valid}, 0);
        check_eq({tag, "_end_data"}, {16'b0, out_data}, 0);
        check_eq({tag, "_end_busy"}, {31'b0, busy}, 0);
    endtask

    initial begin
        #2;
        check_eq("rst_valid", {31'b0, out_valid}, 0);
        check_eq("rst_data", {16'b0, out_data}, 0);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_ovf", {31'b0, overflow}, 0);
        check_eq("rst_count", {27'b0, count}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1) two-word burst
        q = {16'd1024, 16'd512};
        drive_burst();
        check_eq("t1_busy", {31'b0, busy}, 1);
        expect_replay("t1", 2, 1'b0);
        check_eq("t1_ovf", {31'b0, overflow}, 0);
        check_eq("t1_count", {27'b0, count}, 2);

        // 2) single word
        q = {16'hBEEF};
        drive_burst();
        expect_replay("t2", 1, 1'b0);
        check_eq("t2_count", {27'b0, count}, 1);

        // 3) overflow: 19 words, only 16 kept
        q.delete();
        for (int i = 0; i < DEPTH + 3; i++) q.push_back(DATA_W'(i));
        drive_burst();
        expect_replay("t3", DEPTH, 1'b0);
        check_eq("t3_ovf", {31'b0, overflow}, 1);
        check_eq("t3_count", {27'b0, count}, DEPTH);

        // 6) back-to-back bursts; first one also clears the sticky overflow
        q = {16'h000A, 16'h000B, 16'h000C};
        drive_burst();
        expect_replay("t6a", 3, 1'b0);
        check_eq("t6a_ovf", {31'b0, overflow}, 0);
        check_eq("t6a_count", {27'b0, count}, 3);
        q = {16'h000D};
        drive_burst();
        expect_replay("t6b", 1, 1'b0);
        check_eq("t6b_count", {27'b0, count}, 1);

        // 4) in_valid during DRAIN is a protocol error but leaves the replay intact
        q = {16'd1, 16'd2, 16'd3, 16'd4};
        drive_burst();
        expect_replay("t4", 4, 1'b1);
        check_eq("t4_ovf", {31'b0, overflow}, 1);
        check_eq("t4_count", {27'b0, count}, 4);

        // 5) reset in the second DRAIN cycle
        q = {16'h0011, 16'h0022, 16'h0033};
        drive_burst();
        @(negedge clk);
        @(negedge clk);
        check_eq("t5_first", {16'b0, out_data}, 16'h0011);
        @(negedge clk);
        check_eq("t5_second_valid", {31'b0, out_valid}, 1);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_valid", {31'b0, out_valid}, 0);
        check_eq("t5_rst_data", {16'b0, out_data}, 0);
        check_eq("t5_rst_busy", {31'b0, busy}, 0);
        check_eq("t5_rst_count", {27'b0, count}, 0);
        check_eq("t5_rst_ovf", {31'b0, overflow}, 0);
        @(negedge clk);
        rst = 1'b0;
        q = {16'd7, 16'd8};
        drive_burst();
        expect_replay("t5", 2, 1'b0);
        check_eq("t5_count", {27'b0, count}, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
